// File: rtl/cpu_pkg.sv
// Shared integer-pipeline widths and the reservation-station entry layout.
package cpu_pkg;

    localparam int TAG_W     = 6;
    localparam int DATA_W    = 32;
    localparam int PAYLOAD_W = 49;

    typedef struct packed {
        logic                 valid;
        logic [PAYLOAD_W-1:0] payload;
        logic [TAG_W-1:0]     src1_tag;
        logic                 src1_rdy;
        logic [DATA_W-1:0]    src1_val;
        logic [TAG_W-1:0]     src2_tag;
        logic                 src2_rdy;
        logic [DATA_W-1:0]    src2_val;
    } rs_entry_t;

endpackage

// File: rtl/rs_oldest_select.sv
// Oldest-ready pick from an age matrix: older_i[i][j] set means entry j is older than entry i.
module rs_oldest_select #(
    parameter int N = 8
) (
    input  logic [N-1:0]        ready_i,
    input  logic [N-1:0][N-1:0] older_i,
    output logic [N-1:0]        grant_o,
    output logic                any_grant_o
);

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < N; i++) begin
            grant_o[i] = ready_i[i] && !(|(ready_i & older_i[i]));
        end
        any_grant_o = |grant_o;
    end

endmodule

// File: rtl/issue_scheduler.sv
// Reservation station with CDB wakeup and oldest-ready issue into a registered valid/ready port.
module issue_scheduler
    import cpu_pkg::*;
#(
    parameter  int NUM_ENTRIES = 8,
    localparam int OCC_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [PAYLOAD_W-1:0] disp_payload,
    input  logic [TAG_W-1:0]     disp_src1_tag,
    input  logic [TAG_W-1:0]     disp_src2_tag,
    input  logic                 disp_src1_rdy,
    input  logic                 disp_src2_rdy,
    input  logic [DATA_W-1:0]    disp_src1_val,
    input  logic [DATA_W-1:0]    disp_src2_val,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [DATA_W-1:0]    cdb_value,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output logic [PAYLOAD_W-1:0] iss_payload,
    output logic [DATA_W-1:0]    iss_src1_val,
    output logic [DATA_W-1:0]    iss_src2_val,
    output logic [OCC_W-1:0]     occupancy
);

    rs_entry_t ent_q [NUM_ENTRIES];
    rs_entry_t ent_d [NUM_ENTRIES];
    rs_entry_t new_ent;
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_q, older_d;
    logic [NUM_ENTRIES-1:0] valid_vec, ready_vec, free_oh, grant;
    logic                   any_grant, accept, load;
    logic                   iss_valid_q, iss_valid_d;
    logic [PAYLOAD_W-1:0]   iss_payload_q, iss_payload_d, sel_payload;
    logic [DATA_W-1:0]      iss_src1_q, iss_src1_d, sel_src1;
    logic [DATA_W-1:0]      iss_src2_q, iss_src2_d, sel_src2;
    logic [OCC_W-1:0]       occ_q, occ_d;

    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid_vec[i] = ent_q[i].valid;
            ready_vec[i] = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy;
        end
    end

    // Registered-state only: a same-cycle issue does not open a slot until the next cycle.
    assign disp_ready = ~&valid_vec;
    assign accept     = disp_valid && disp_ready && !flush;
    assign free_oh    = ~valid_vec & (valid_vec + NUM_ENTRIES'(1));

    rs_oldest_select #(.N(NUM_ENTRIES)) u_sel (
        .ready_i     (ready_vec),
        .older_i     (older_q),
        .grant_o     (grant),
        .any_grant_o (any_grant)
    );

    assign load = (!iss_valid_q || iss_ready) && any_grant && !flush;

    always_comb begin
        sel_payload = '0;
        sel_src1    = '0;
        sel_src2    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (grant[i]) begin
                sel_payload = sel_payload | ent_q[i].payload;
                sel_src1    = sel_src1 | ent_q[i].src1_val;
                sel_src2    = sel_src2 | ent_q[i].src2_val;
            end
        end
    end

    // A source still waiting at dispatch can be satisfied by the broadcast of the same cycle.
    always_comb begin
        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.payload  = disp_payload;
        new_ent.src1_tag = disp_src1_tag;
        new_ent.src2_tag = disp_src2_tag;
        new_ent.src1_rdy = disp_src1_rdy || (cdb_valid && cdb_tag == disp_src1_tag);
        new_ent.src2_rdy = disp_src2_rdy || (cdb_valid && cdb_tag == disp_src2_tag);
        new_ent.src1_val = disp_src1_rdy ? disp_src1_val : cdb_value;
        new_ent.src2_val = disp_src2_rdy ? disp_src2_val : cdb_value;
    end

    always_comb begin
        ent_d   = ent_q;
        older_d = older_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (cdb_valid && ent_q[i].valid) begin
                if (!ent_q[i].src1_rdy && ent_q[i].src1_tag == cdb_tag) begin
                    ent_d[i].src1_rdy = 1'b1;
                    ent_d[i].src1_val = cdb_value;
                end
                if (!ent_q[i].src2_rdy && ent_q[i].src2_tag == cdb_tag) begin
                    ent_d[i].src2_rdy = 1'b1;
                    ent_d[i].src2_val = cdb_value;
                end
            end
            if (load && grant[i]) ent_d[i].valid = 1'b0;
            // Clearing the column drops stale "older" bits left by this slot's previous occupant.
            if (accept && free_oh[i]) begin
                ent_d[i] = new_ent;
                for (int k = 0; k < NUM_ENTRIES; k++) older_d[k][i] = 1'b0;
                older_d[i]    = valid_vec;
                older_d[i][i] = 1'b0;
            end
            if (flush) ent_d[i].valid = 1'b0;
        end
    end

    always_comb begin
        iss_valid_d   = iss_valid_q;
        iss_payload_d = iss_payload_q;
        iss_src1_d    = iss_src1_q;
        iss_src2_d    = iss_src2_q;
        if (flush) begin
            iss_valid_d = 1'b0;
        end else if (load) begin
            iss_valid_d   = 1'b1;
            iss_payload_d = sel_payload;
            iss_src1_d    = sel_src1;
            iss_src2_d    = sel_src2;
        end else if (iss_ready) begin
            iss_valid_d = 1'b0;
        end
        occ_d = flush ? '0 : occ_q + OCC_W'(accept) - OCC_W'(load);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= '0;
            older_q       <= '0;
            iss_valid_q   <= 1'b0;
            iss_payload_q <= '0;
            iss_src1_q    <= '0;
            iss_src2_q    <= '0;
            occ_q         <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= ent_d[i];
            older_q       <= older_d;
            iss_valid_q   <= iss_valid_d;
            iss_payload_q <= iss_payload_d;
            iss_src1_q    <= iss_src1_d;
            iss_src2_q    <= iss_src2_d;
            occ_q         <= occ_d;
        end
    end

    assign iss_valid    = iss_valid_q;
    assign iss_payload  = iss_payload_q;
    assign iss_src1_val = iss_src1_q;
    assign iss_src2_val = iss_src2_q;
    assign occupancy    = occ_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: dispatch-bypass vector table, directed corner sequences, random run vs. queue model.
module tb_issue_scheduler;

    logic        clk = 1'b0;
    logic        reset_n, flush, disp_valid, disp_ready;
    logic [48:0] disp_payload;
    logic [5:0]  disp_src1_tag, disp_src2_tag;
    logic        disp_src1_rdy, disp_src2_rdy;
    logic [31:0] disp_src1_val, disp_src2_val;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        iss_valid, iss_ready;
    logic [48:0] iss_payload;
    logic [31:0] iss_src1_val, iss_src2_val;
    logic [3:0]  occupancy;

    issue_scheduler #(.NUM_ENTRIES(8)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_payload(disp_payload),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
        .iss_src1_val(iss_src1_val), .iss_src2_val(iss_src2_val), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        r1, r2;
        logic [5:0]  t1, t2;
        logic [31:0] v1, v2;
        logic        cv;
        logic [5:0]  ct;
        logic [31:0] cval;
        logic        exp_iss;
        logic [31:0] e1, e2;
    } vec_t;
    vec_t tbl [8];

    typedef struct {
        logic [48:0] p;
        logic        r1, r2;
        logic [5:0]  t1, t2;
        logic [31:0] v1, v2;
    } mop_t;
    mop_t q[$];
    mop_t m_iss;
    logic m_iv = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        flush = 0; disp_valid = 0; cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
        disp_payload = 0; disp_src1_tag = 0; disp_src2_tag = 0;
        disp_src1_rdy = 0; disp_src2_rdy = 0; disp_src1_val = 0; disp_src2_val = 0;
    endtask

    task automatic drv(input logic [48:0] p, input logic r1, input logic r2, input logic [5:0] t1,
                       input logic [5:0] t2, input logic [31:0] v1, input logic [31:0] v2);
        disp_valid = 1; disp_payload = p; disp_src1_rdy = r1; disp_src2_rdy = r2;
        disp_src1_tag = t1; disp_src2_tag = t2; disp_src1_val = v1; disp_src2_val = v2;
    endtask

    task automatic do_flush();
        idle_in(); flush = 1; step(); flush = 0;
    endtask

    // Reference: queue in dispatch order; oldest ready = first fully-ready element.
    task automatic mdl_edge();
        int   sel;
        logic room;
        mop_t n;
        if (flush) begin
            q.delete();
            m_iv = 0;
            return;
        end
        sel  = -1;
        room = (q.size() < 8);
        for (int k = 0; k < q.size(); k++)
            if (sel < 0 && q[k].r1 && q[k].r2) sel = k;
        if ((!m_iv || iss_ready) && sel >= 0) begin
            m_iss = q[sel]; m_iv = 1; q.delete(sel);
        end else if (iss_ready) m_iv = 0;
        if (cdb_valid)
            for (int k = 0; k < q.size(); k++) begin
                if (!q[k].r1 && q[k].t1 == cdb_tag) begin q[k].r1 = 1; q[k].v1 = cdb_value; end
                if (!q[k].r2 && q[k].t2 == cdb_tag) begin q[k].r2 = 1; q[k].v2 = cdb_value; end
            end
        if (disp_valid && room) begin
            n.p  = disp_payload; n.t1 = disp_src1_tag; n.t2 = disp_src2_tag;
            n.r1 = disp_src1_rdy || (cdb_valid && cdb_tag == disp_src1_tag);
            n.r2 = disp_src2_rdy || (cdb_valid && cdb_tag == disp_src2_tag);
            n.v1 = disp_src1_rdy ? disp_src1_val : cdb_value;
            n.v2 = disp_src2_rdy ? disp_src2_val : cdb_value;
            q.push_back(n);
        end
    endtask

    initial begin
        logic [63:0] r64;
        tbl[0] = '{1, 1, 1, 2, 32'h11, 32'h22, 0, 0, 0, 1, 32'h11, 32'h22};
        tbl[1] = '{1, 0, 1, 9, 32'hAA, 32'h0, 1, 9, 32'h1234, 1, 32'hAA, 32'h1234};
        tbl[2] = '{0, 1, 3, 0, 32'h0, 32'hBB, 1, 3, 32'h5555, 1, 32'h5555, 32'hBB};
        tbl[3] = '{0, 0, 7, 7, 32'h0, 32'h0, 1, 7, 32'h7777, 1, 32'h7777, 32'h7777};
        tbl[4] = '{0, 1, 4, 0, 32'h0, 32'h1, 1, 5, 32'h9999, 0, 32'h0, 32'h0};
        tbl[5] = '{1, 1, 5, 5, 32'hCC, 32'hDD, 1, 5, 32'hEE, 1, 32'hCC, 32'hDD};
        tbl[6] = '{0, 1, 6, 0, 32'h0, 32'h1, 0, 6, 32'h66, 0, 32'h0, 32'h0};
        tbl[7] = '{1, 0, 0, 2, 32'h3, 32'h0, 1, 1, 32'h44, 0, 32'h0, 32'h0};

        idle_in(); iss_ready = 0; reset_n = 0;
        repeat (2) step();
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_iss_payload", iss_payload, 0);
        reset_n = 1;
        step();

        // Single op from an empty station, with and without same-cycle CDB bypass.
        iss_ready = 1;
        for (int v = 0; v < 8; v++) begin
            do_flush();
            drv(49'h100 + 49'(v), tbl[v].r1, tbl[v].r2, tbl[v].t1, tbl[v].t2, tbl[v].v1, tbl[v].v2);
            cdb_valid = tbl[v].cv; cdb_tag = tbl[v].ct; cdb_value = tbl[v].cval;
            step();
            chk("vec_occ_after_disp", occupancy, 1);
            idle_in();
            step();
            chk("vec_iss_valid", iss_valid, tbl[v].exp_iss);
            chk("vec_occ", occupancy, tbl[v].exp_iss ? 0 : 1);
            if (tbl[v].exp_iss) begin
                chk("vec_payload", iss_payload, 49'h100 + 49'(v));
                chk("vec_src1", iss_src1_val, tbl[v].e1);
                chk("vec_src2", iss_src2_val, tbl[v].e2);
            end
        end

        // In-order A, B, C back to back.
        do_flush();
        drv(49'hA, 1, 1, 0, 0, 32'hA1, 32'hA2); step();
        drv(49'hB, 1, 1, 0, 0, 32'hB1, 32'hB2); step();
        chk("abc_A", iss_payload, 49'hA); chk("abc_A_v", iss_valid, 1); chk("abc_A_s2", iss_src2_val, 32'hA2);
        drv(49'hC, 1, 1, 0, 0, 32'hC1, 32'hC2); step();
        chk("abc_B", iss_payload, 49'hB); chk("abc_B_s1", iss_src1_val, 32'hB1);
        idle_in(); step();
        chk("abc_C", iss_payload, 49'hC); chk("abc_C_v", iss_valid, 1);
        step();
        chk("abc_drain_v", iss_valid, 0); chk("abc_drain_occ", occupancy, 0);

        // Younger ready op overtakes an older waiting one; wakeup then releases the older.
        do_flush();
        drv(49'hA, 0, 1, 5, 0, 32'h0, 32'h2); step();
        drv(49'hB, 1, 1, 0, 0, 32'h1, 32'h2); step();
        chk("age_none_yet", iss_valid, 0);
        idle_in(); step();
        chk("age_B_first", iss_payload, 49'hB); chk("age_B_v", iss_valid, 1);
        cdb_valid = 1; cdb_tag = 5; cdb_value = 32'hDEADBEEF; step();
        chk("age_gap", iss_valid, 0);
        idle_in(); step();
        chk("age_A_v", iss_valid, 1); chk("age_A", iss_payload, 49'hA);
        chk("age_A_src1", iss_src1_val, 32'hDEADBEEF);

        // Backpressure until full, then release.
        do_flush(); iss_ready = 0;
        drv(49'h1000, 1, 1, 0, 0, 32'h500, 32'h600); step();
        idle_in(); step();
        chk("full_p0_loaded", iss_valid, 1);
        for (int k = 1; k <= 9; k++) begin
            drv(49'h1000 + 49'(k), 1, 1, 0, 0, 32'(k), 32'(k)); step();
        end
        chk("full_occ", occupancy, 8); chk("full_disp_ready", disp_ready, 0);
        chk("full_hold_payload", iss_payload, 49'h1000); chk("full_hold_src1", iss_src1_val, 32'h500);
        step();
        chk("full_refuse_occ", occupancy, 8);
        idle_in(); iss_ready = 1; step();
        chk("full_release_payload", iss_payload, 49'h1001);
        chk("full_release_occ", occupancy, 7); chk("full_release_ready", disp_ready, 1);
        for (int k = 2; k <= 8; k++) begin
            step(); chk("full_drain_payload", iss_payload, 49'h1000 + 49'(k));
        end
        step();
        chk("full_no_p9", iss_valid, 0);

        // Flush with 5 valid entries and a live issue register, colliding with a dispatch.
        do_flush(); iss_ready = 0;
        for (int k = 0; k < 6; k++) begin
            drv(49'h2000 + 49'(k), 1, 1, 0, 0, 32'h1, 32'h2); step();
        end
        chk("fl_pre_occ", occupancy, 5); chk("fl_pre_iv", iss_valid, 1);
        drv(49'h2FFF, 1, 1, 0, 0, 32'h1, 32'h2); flush = 1; step();
        chk("fl_occ", occupancy, 0); chk("fl_iv", iss_valid, 0); chk("fl_disp_ready", disp_ready, 1);
        idle_in(); iss_ready = 1; step(); step();
        chk("fl_discard_iv", iss_valid, 0); chk("fl_discard_occ", occupancy, 0);

        // Asynchronous reset between clock edges.
        do_flush(); iss_ready = 0;
        for (int k = 0; k < 4; k++) begin
            drv(49'h3000 + 49'(k), 1, 1, 0, 0, 32'h7, 32'h8); step();
        end
        chk("ar_pre_occ", occupancy, 3);
        idle_in();
        #3 reset_n = 0;
        #1;
        chk("ar_occ", occupancy, 0); chk("ar_iv", iss_valid, 0); chk("ar_disp_ready", disp_ready, 1);
        chk("ar_payload", iss_payload, 0); chk("ar_src1", iss_src1_val, 0);
        #2 reset_n = 1;
        step();
        chk("ar_after_occ", occupancy, 0);

        // Random traffic against the queue model.
        q.delete(); m_iv = 0;
        for (int c = 0; c < 2000; c++) begin
            chk("rnd_iss_valid", iss_valid, m_iv);
            if (m_iv) begin
                chk("rnd_payload", iss_payload, m_iss.p);
                chk("rnd_src1", iss_src1_val, m_iss.v1);
                chk("rnd_src2", iss_src2_val, m_iss.v2);
            end
            chk("rnd_occ", occupancy, q.size());
            chk("rnd_disp_ready", disp_ready, q.size() < 8);
            r64 = {$urandom(), $urandom()};
            flush         = ($urandom_range(99) < 3);
            disp_valid    = ($urandom_range(99) < 60);
            disp_payload  = r64[48:0];
            disp_src1_rdy = $urandom_range(1);
            disp_src2_rdy = $urandom_range(1);
            disp_src1_tag = 6'($urandom_range(3));
            disp_src2_tag = 6'($urandom_range(3));
            disp_src1_val = $urandom();
            disp_src2_val = $urandom();
            cdb_valid     = ($urandom_range(99) < 50);
            cdb_tag       = 6'($urandom_range(3));
            cdb_value     = $urandom();
            iss_ready     = ($urandom_range(99) < 70);
            mdl_edge();
            step();
        end
        chk("rnd_final_occ", occupancy, q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Single-port reservation station and issue scheduler between decode/rename and the integer execute unit. It holds up to NUM_ENTRIES decoded micro-ops and captures source operands from the common data bus (CDB). Each cycle it selects the oldest micro-op whose operands are all ready and issues it through a registered valid/ready port. It is the control point that sequences the ID→EX datapath out of order.

## Interface
- NUM_ENTRIES, 8: station depth; ≥2, need not be a power of two.
- TAG_W, 6: physical/ROB tag width.
- DATA_W, 32: operand width.
- PAYLOAD_W, 49: opaque micro-op bits (opcode, funct3, funct7, dest tag, immediate); never interpreted.

- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all entries and of the issue register.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  a free entry exists.
- disp_payload  in  PAYLOAD_W  micro-op bits.
- disp_src1_tag / disp_src2_tag  in  TAG_W  producer tags.
- disp_src1_rdy / disp_src2_rdy  in  1  operand already available.
- disp_src1_val / disp_src2_val  in  DATA_W  operand values, meaningful when rdy.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  TAG_W  tag of the broadcast result.
- cdb_value  in  DATA_W  broadcast value.
- iss_valid  out  1  issue register holds a micro-op.
- iss_ready  in  1  execute unit accepts.
- iss_payload  out  PAYLOAD_W; iss_src1_val / iss_src2_val  out  DATA_W.
- occupancy  out  $clog2(NUM_ENTRIES+1)  number of valid entries.

## Operation
- Each entry holds valid, payload, and for each source a tag, a rdy bit and a value. The entry is READY when valid and both rdy bits are set.
- Dispatch handshake:
  - A micro-op is accepted when disp_valid && disp_ready && !flush.
  - It is written to the lowest-index free entry.
  - disp_ready is derived from registered state only: it is true when any entry is free. It does not anticipate a same-cycle issue.
- Dispatch bypass: if a source has disp_srcN_rdy=0 and cdb_valid with cdb_tag==disp_srcN_tag in the same cycle, the CDB value is captured and rdy is set at write time.
- Wakeup: every valid non-ready source whose tag equals cdb_tag while cdb_valid captures cdb_value and sets rdy. Multiple entries and both sources may wake on one broadcast.
- Age ordering:
  - Use an N×N age matrix. When entry i is written, older[i][j] = valid[j] for all j≠i.
  - Select the READY entry i for which no READY j has older[i][j] set. The selection is one-hot, so ties cannot occur.
- Issue register:
  - It loads when (!iss_valid || iss_ready) and a READY entry exists.
  - On load, the selected entry is freed on the same edge.
  - If iss_valid && iss_ready and nothing is READY, iss_valid falls.
  - While iss_valid && !iss_ready, the outputs hold stable.
- occupancy = popcount(valid). It is updated by +1 on dispatch, −1 on a load into the issue register, and is unchanged when both happen in the same cycle.
- flush clears every valid bit and iss_valid on the next edge. It overrides dispatch, wakeup and issue in that cycle.
- Reset values: all entries invalid, iss_valid=0, occupancy=0, disp_ready=1, iss_payload and iss_src values 0.

## Timing
- Dispatch with both sources ready on edge E0 → iss_valid=1 after E1 (minimum latency 2 edges).
- CDB wakeup captured on edge E0 → entry eligible in cycle after E0 → iss_valid after E1.
- Back-to-back issue: one micro-op per cycle while iss_ready=1 and READY entries exist.
- Full station: disp_ready=0 for the whole cycle, even if an entry issues on that edge. It rises the cycle after the entry is freed.
- Reset asserted mid-operation clears state immediately, independent of clk.

## Structure
- The shared package cpu_pkg defines TAG_W, DATA_W and PAYLOAD_W, and the rs_entry_t typedef (valid, payload, src tag/rdy/val ×2).
- Sub-module rs_oldest_select: combinational; inputs are the ready vector and the age matrix; output is a one-hot grant plus an any_grant flag. It is reusable by later memory and branch stations.
- Free-slot selection is an inline lowest-index priority encoder.

## Test plan
- After reset: disp_ready=1, occupancy=0, iss_valid=0. Dispatch ops A, B, C (all sources rdy) on consecutive cycles with iss_ready=1 → issued in order A, B, C on consecutive cycles, values intact.
- Age priority: dispatch A (src1 tag 5, not rdy), then B (rdy) → B issues first. Then CDB tag 5, value 0xDEADBEEF → A issues two cycles later with iss_src1_val=0xDEADBEEF.
- Same-cycle bypass: dispatch with src2 tag 9 not rdy while cdb_valid, tag 9, value 0x1234 → issues with iss_src2_val=0x1234 and never waits.
- Backpressure and full: iss_ready=0, dispatch 9 ready ops → 8 accepted, disp_ready=0, occupancy=8, issue outputs stable. Release iss_ready → disp_ready=1 the cycle after the first entry is freed.
- Flush with 5 entries valid and iss_valid=1, concurrent with a dispatch → next cycle occupancy=0, iss_valid=0, dispatched op discarded.
- Assert reset_n low mid-cycle with 3 entries valid → outputs reach reset values without a clock edge.
